// File: rtl/skid_stage_buffer.sv
// Two-entry valid/ready pipeline register: out/outValid/inReady come straight from flops.
// One-cycle latency. Absorbs one extra word when downstream stalls, so inReady may lag by a cycle.
module skid_stage_buffer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] in,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       occupancy
);

    // Bit 0 is mainValid and bit 1 is skidValid, so the flags are plain flop outputs.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_accept;
    logic             w_drain;

    assign w_accept = inValid & ~r_state[1];
    assign w_drain  = r_state[0] & outReady;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_main_nxt  = in;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_main_nxt = in;
                end else if (w_accept) begin
                    w_skid_nxt  = in;
                    w_state_nxt = S_FULL;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_drain) begin
                    w_main_nxt  = r_skid_data;
                    w_state_nxt = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Reset and flush have identical effect; either one overrides all handshake activity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_VALUE;
            r_skid_data <= RESET_VALUE;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_VALUE;
            r_skid_data <= RESET_VALUE;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
        end
    end

    assign inReady   = ~r_state[1];
    assign outValid  = r_state[0];
    assign out       = r_main_data;
    assign occupancy = {1'b0, r_state[0]} + {1'b0, r_state[1]};

endmodule

// File: tb/tb_skid_stage_buffer.sv
// Scoreboard bench: accepted words queue up, drained words are compared against the queue head.
module tb_skid_stage_buffer;

    localparam logic [31:0] RST32 = 32'h0;
    localparam logic [15:0] RST16 = 16'h7000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_dat;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_dat;
    logic [1:0]  occ;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] out_dat16;
    logic [1:0]  occ16;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] sb_q[$];
    logic [31:0] m_out;
    logic        acc;

    always #5 clk = ~clk;

    skid_stage_buffer #(.WIDTH(32), .RESET_VALUE(RST32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .inValid   (in_valid),
        .inReady   (in_ready),
        .in        (in_dat),
        .outValid  (out_valid),
        .outReady  (out_ready),
        .out       (out_dat),
        .occupancy (occ)
    );

    skid_stage_buffer #(.WIDTH(16), .RESET_VALUE(RST16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .inValid   (in_valid),
        .inReady   (in_ready16),
        .in        (in_dat[15:0]),
        .outValid  (out_valid16),
        .outReady  (out_ready),
        .out       (out_dat16),
        .occupancy (occ16)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".occ"},      {30'd0, occ},       sb_q.size());
        chk({tag, ".in_rdy"},   {31'd0, in_ready},  {31'd0, sb_q.size() < 2});
        chk({tag, ".out_vld"},  {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
        chk({tag, ".out"},      out_dat,            m_out);
    endtask

    // One clock: drive inputs, predict handshake from the model, advance, check.
    task automatic step(input string tag, input logic iv, input logic [31:0] d,
                        input logic ordy, input logic fl, input logic rs,
                        output logic accepted);
        logic drn;
        rst       = rs;
        flush     = fl;
        in_valid  = iv;
        in_dat    = d;
        out_ready = ordy;
        accepted  = iv && (sb_q.size() < 2);
        drn       = (sb_q.size() != 0) && ordy;
        if (drn) chk({tag, ".sb"}, out_dat, sb_q[0]);
        @(posedge clk);
        if (!rs || fl) begin
            sb_q.delete();
            m_out    = RST32;
            accepted = 1'b0;
        end else begin
            if (drn) void'(sb_q.pop_front());
            if (accepted) sb_q.push_back(d);
            if (sb_q.size() != 0) m_out = sb_q[0];
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m_out = RST32;
        // Reset held two edges with a word offered
        step("rst0", 1'b1, 32'hABABABAB, 1'b0, 1'b0, 1'b0, acc);
        step("rst1", 1'b1, 32'hABABABAB, 1'b0, 1'b0, 1'b0, acc);
        chk("rst16.out", {16'd0, out_dat16}, {16'd0, RST16});
        step("rel", 1'b1, 32'hABABABAB, 1'b1, 1'b0, 1'b1, acc);
        chk("rel.out_explicit", out_dat, 32'hABABABAB);
        step("rel_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

        // Streaming
        for (int i = 1; i <= 8; i++)
            step("stream", 1'b1, i, 1'b1, 1'b0, 1'b1, acc);
        step("stream_end", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

        // Stall and skid
        step("stall_a", 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, acc);
        step("stall_b", 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, acc);
        step("stall_c", 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, acc);
        step("stall_d", 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++)
            step("unstall", 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, acc);
        chk("unstall.accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++)
            step("unstall_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

        // Flush from FULL with a word offered
        step("fl_a", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, acc);
        step("fl_b", 1'b1, 32'hBBBBBBBB, 1'b0, 1'b0, 1'b1, acc);
        step("flush", 1'b1, 32'hCCCCCCCC, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++)
            step("post_flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

        // Simultaneous drain and accept in ONE
        step("sim_a", 1'b1, 32'h12780000, 1'b0, 1'b0, 1'b1, acc);
        step("sim_b", 1'b1, 32'hDADA0000, 1'b1, 1'b0, 1'b1, acc);
        chk("sim.out_explicit", out_dat, 32'hDADA0000);

        // Reset and flush together, checked on the 16-bit instance
        step("p_a", 1'b1, 32'h00001234, 1'b1, 1'b0, 1'b1, acc);
        chk("p16.mid_out", {16'd0, out_dat16}, 32'h00001234);
        chk("p16.mid_vld", {31'd0, out_valid16}, 32'd1);
        step("p_rf", 1'b1, 32'h00005555, 1'b1, 1'b1, 1'b0, acc);
        chk("p16.out", {16'd0, out_dat16}, {16'd0, RST16});
        chk("p16.vld", {31'd0, out_valid16}, 32'd0);
        chk("p16.occ", {30'd0, occ16}, 32'd0);
        chk("p16.rdy", {31'd0, in_ready16}, 32'd1);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 40) == 0), 1'b1, acc);
        for (int i = 0; i < 3; i++)
            step("final_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
